// File: rtl/vending_machine_if.sv
// Coin-acceptor / dispenser bundle for vending_machine.
// The master drives deposits and selections; the slave returns item and change pulses.
interface vending_machine_if;
  logic [7:0] amount;
  logic [2:0] selection;
  logic [4:0] change_nickels;
  logic [3:0] change_dimes;
  logic [1:0] change_quarters;
  logic       change_dollar;
  logic [2:0] item_dispensed;

  modport master (
    output amount,
    output selection,
    input  change_nickels,
    input  change_dimes,
    input  change_quarters,
    input  change_dollar,
    input  item_dispensed
  );

  modport slave (
    input  amount,
    input  selection,
    output change_nickels,
    output change_dimes,
    output change_quarters,
    output change_dollar,
    output item_dispensed
  );
endinterface

// File: rtl/vending_machine.sv
// Coin-credit vending controller: accumulates credit, vends, pays greedy change.
// Optional COIN_RETURN_EN turns selection 7 into a coin-return request.
module vending_machine (
  input logic             clock,
  input logic             reset,
  vending_machine_if.slave bus
);

  typedef struct packed {
    logic       dollar;
    logic [1:0] quarters;
    logic [3:0] dimes;
    logic [4:0] nickels;
  } change_t;

  localparam logic [8:0] CREDIT_MAX = 9'd250;

  function automatic logic coin_ok(input logic [7:0] a);
    coin_ok = ((a % 8'd5) == 8'd0);
  endfunction

  function automatic logic [7:0] price_of(input logic [2:0] sel);
    case (sel)
      3'd1:    price_of = 8'd50;
      3'd2:    price_of = 8'd65;
      3'd3:    price_of = 8'd75;
      3'd4:    price_of = 8'd85;
      3'd5:    price_of = 8'd100;
      3'd6:    price_of = 8'd120;
      3'd7:    price_of = 8'd150;
      default: price_of = 8'd0;
    endcase
  endfunction

  // Largest coins first; dollar capped at 1, quarters at 3, dimes at 15.
  function automatic change_t greedy(input logic [9:0] cents);
    logic [9:0] rem;
    logic [9:0] dimes;
    change_t    res;
    res = '0;
    rem = cents;
    if (rem >= 10'd100) begin
      res.dollar = 1'b1;
      rem        = rem - 10'd100;
    end else begin
      res.dollar = 1'b0;
    end
    if (rem >= 10'd75) begin
      res.quarters = 2'd3;
      rem          = rem - 10'd75;
    end else if (rem >= 10'd50) begin
      res.quarters = 2'd2;
      rem          = rem - 10'd50;
    end else if (rem >= 10'd25) begin
      res.quarters = 2'd1;
      rem          = rem - 10'd25;
    end else begin
      res.quarters = 2'd0;
    end
    dimes = rem / 10'd10;
    if (dimes > 10'd15) begin
      dimes = 10'd15;
    end else begin
      dimes = dimes;
    end
    rem         = rem - (dimes * 10'd10);
    res.dimes   = 4'(dimes);
    res.nickels = 5'(rem / 10'd5);
    greedy      = res;
  endfunction

  logic [7:0] w_deposit;
  logic [9:0] w_sum;
  logic [7:0] w_price;
  logic       w_coin_return;
  logic       w_vend;
  logic [9:0] w_change_cents;
  logic [2:0] w_item_next;
  logic [8:0] w_credit_next;
  change_t    w_change;

  logic [8:0] r_credit;
  logic [2:0] r_item;
  change_t    r_change;

  // Next-credit, dispense and change decision for this cycle's inputs.
  always_comb begin
    w_deposit      = coin_ok(bus.amount) ? bus.amount : 8'd0;
    w_sum          = {1'b0, r_credit} + {2'b00, w_deposit};
    w_price        = price_of(bus.selection);
`ifdef COIN_RETURN_EN
    w_coin_return  = (bus.selection == 3'd7);
`else
    w_coin_return  = 1'b0;
`endif
    w_vend         = (bus.selection != 3'd0) && !w_coin_return &&
                     (w_sum >= {2'b00, w_price});
    w_change_cents = 10'd0;
    w_item_next    = 3'd0;
    w_credit_next  = r_credit;
    if (w_coin_return) begin
      w_change_cents = w_sum;
      w_item_next    = 3'd0;
      w_credit_next  = 9'd0;
    end else if (w_vend) begin
      w_change_cents = w_sum - {2'b00, w_price};
      w_item_next    = bus.selection;
      w_credit_next  = 9'd0;
    end else begin
      w_change_cents = 10'd0;
      w_item_next    = 3'd0;
      // Deposits beyond the credit ceiling are forfeited.
      w_credit_next  = (w_sum > {1'b0, CREDIT_MAX}) ? CREDIT_MAX : w_sum[8:0];
    end
    w_change = greedy(w_change_cents);
  end

  // Credit and output pulse registers; reset discards the cycle's inputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_credit <= 9'd0;
      r_item   <= 3'd0;
      r_change <= '0;
    end else begin
      r_credit <= w_credit_next;
      r_item   <= w_item_next;
      r_change <= w_change;
    end
  end

  assign bus.item_dispensed  = r_item;
  assign bus.change_dollar   = r_change.dollar;
  assign bus.change_quarters = r_change.quarters;
  assign bus.change_dimes    = r_change.dimes;
  assign bus.change_nickels  = r_change.nickels;

endmodule

// File: tb/tb_vending_machine.sv
// Self-checking bench for vending_machine: directed scenarios with literal
// expectations plus randomized traffic checked against a behavioural model.
module tb_vending_machine;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  vending_machine_if vif ();

  vending_machine dut (
    .clock (clock),
    .reset (reset),
    .bus   (vif.slave)
  );

  int          tests = 0;
  int          fails = 0;
  int          credit = 0;
  bit          exp_valid = 1'b0;
  logic [14:0] exp_vec;
  logic [14:0] dut_vec;
  int          prices [8] = '{0, 50, 65, 75, 85, 100, 120, 150};

  assign dut_vec = {vif.item_dispensed, vif.change_dollar, vif.change_quarters,
                    vif.change_dimes, vif.change_nickels};

  // Hand out coins one at a time, biggest first, honouring per-coin caps.
  task automatic coins(input int cents, output int dol, output int q,
                       output int d, output int n);
    int c;
    c = cents; dol = 0; q = 0; d = 0; n = 0;
    while (c >= 100 && dol < 1)  begin dol++; c -= 100; end
    while (c >= 25  && q   < 3)  begin q++;   c -= 25;  end
    while (c >= 10  && d   < 15) begin d++;   c -= 10;  end
    while (c >= 5)               begin n++;   c -= 5;   end
  endtask

  task automatic model(input int a, input int s, input bit r);
    int sum, item, chg, dol, q, d, n;
    item = 0; chg = 0;
    if (r) begin
      credit = 0;
    end else begin
      sum = credit + ((a % 5 == 0) ? a : 0);
`ifdef COIN_RETURN_EN
      if (s == 7) begin
        chg = sum; credit = 0;
      end else
`endif
      if (s != 0 && sum >= prices[s]) begin
        item = s; chg = sum - prices[s]; credit = 0;
      end else begin
        credit = (sum > 250) ? 250 : sum;
      end
    end
    coins(chg, dol, q, d, n);
    exp_vec = {3'(item), 1'(dol), 2'(q), 4'(d), 5'(n)};
  endtask

  task automatic step(input int a, input int s, input bit r);
    reset         = r;
    vif.amount    = 8'(a);
    vif.selection = 3'(s);
    @(posedge clock);
    model(a, s, r);
    exp_valid = 1'b1;
    #1;
  endtask

  task automatic expect_out(input string name, input int item, input int dol,
                            input int q, input int d, input int n);
    logic [14:0] want;
    want = {3'(item), 1'(dol), 2'(q), 4'(d), 5'(n)};
    tests++;
    if (dut_vec !== want) begin
      fails++;
      $display("FAIL %s: got item=%0d $=%0d q=%0d d=%0d n=%0d, want item=%0d $=%0d q=%0d d=%0d n=%0d",
               name, dut_vec[14:12], dut_vec[11], dut_vec[10:9], dut_vec[8:5], dut_vec[4:0],
               item, dol, q, d, n);
    end
  endtask

  // Every cycle: DUT outputs must agree with the behavioural model.
  always @(negedge clock) begin
    if (exp_valid) begin
      tests++;
      if (dut_vec !== exp_vec) begin
        fails++;
        $display("FAIL model_cmp t=%0t: got %h want %h", $time, dut_vec, exp_vec);
      end
    end
  end

  initial begin
    int a, s, kind;
    bit r;
    reset = 1'b1;
    vif.amount = 8'd0;
    vif.selection = 3'd0;
    step(0, 0, 1);
    step(0, 0, 1);
    expect_out("reset", 0, 0, 0, 0, 0);

    for (int i = 0; i < 3; i++) begin
      step(5, 6, 0);
      expect_out("small_no_vend", 0, 0, 0, 0, 0);
    end
    step(105, 6, 0);
    expect_out("vend6_exact", 6, 0, 0, 0, 0);

    step(100, 0, 0);
    step(25, 2, 0);
    expect_out("vend2_change60", 2, 0, 2, 1, 0);
    step(0, 0, 0);
    expect_out("pulse_clears", 0, 0, 0, 0, 0);

    step(7, 1, 0);
    expect_out("reject7", 0, 0, 0, 0, 0);
    step(50, 1, 0);
    expect_out("vend1_no7", 1, 0, 0, 0, 0);

    step(250, 0, 0);
    step(100, 0, 0);
    step(0, 4, 0);
    expect_out("saturate_vend4", 4, 1, 2, 1, 1);

    step(100, 5, 1);
    expect_out("reset_discards", 0, 0, 0, 0, 0);
    step(0, 1, 0);
    expect_out("no_credit_after_reset", 0, 0, 0, 0, 0);

    step(100, 0, 0);
    step(80, 0, 0);
    step(0, 7, 0);
`ifdef COIN_RETURN_EN
    expect_out("coin_return180", 0, 1, 3, 0, 1);
`else
    expect_out("vend7_change30", 7, 0, 1, 0, 1);
`endif

    for (int i = 0; i < 3000; i++) begin
      kind = $urandom_range(0, 3);
      case (kind)
        0:       a = 0;
        3:       a = $urandom_range(0, 255);
        default: a = $urandom_range(0, 51) * 5;
      endcase
      s = $urandom_range(0, 7);
      r = ($urandom_range(0, 99) == 0);
      step(a, s, r);
    end

    step(0, 0, 0);
    @(negedge clock);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
